// File: rtl/au_pkg.sv
// Shared definitions for the arbitrated arithmetic unit: op codes, AU command words and
// response flag bit positions.
package au_pkg;

  typedef enum logic [1:0] {
    AU_OP_ADD  = 2'b00,
    AU_OP_SUB  = 2'b01,
    AU_OP_PADD = 2'b10,
    AU_OP_RSVD = 2'b11
  } au_op_e;

  // bit1 = subtract, bit3 = carry chains across the byte boundary
  localparam logic [3:0] AU_CMD_ADD  = 4'b1000;
  localparam logic [3:0] AU_CMD_SUB  = 4'b1010;
  localparam logic [3:0] AU_CMD_PADD = 4'b0000;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  function automatic logic [3:0] op_to_cmd(input logic [1:0] op);
    case (op)
      AU_OP_SUB:  return AU_CMD_SUB;
      AU_OP_PADD: return AU_CMD_PADD;
      default:    return AU_CMD_ADD;
    endcase
  endfunction

endpackage

// File: rtl/au_arbiter_if.sv
// Request, shared-AU and response signals of au_arbiter. The slave modport is the arbiter
// side, master is the side driving requests, the AU sum and the response consumer.
interface au_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [1:0]  req0_op;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [1:0]  req1_op;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic [3:0]  au_cmd;
  logic [15:0] au_a;
  logic [15:0] au_b;
  logic [15:0] au_sum;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_flags;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output au_cmd, au_a, au_b,
    input  au_sum,
    output rsp_valid, rsp_id, rsp_result, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  au_cmd, au_a, au_b,
    output au_sum,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/au_flag_sat.sv
// Overflow/sign/zero flag generation and optional saturation of the raw AU sum.
// AU_SATURATE_EN: clamp overflowing results (per byte for PADD) instead of wrapping.
module au_flag_sat
  import au_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] sum,
  output logic [15:0] result,
  output logic [2:0]  flags
);

  logic [15:0] b_eff;
  logic        v_hi;
  logic        v_lo;
  logic        neg;
  logic        is_padd;

  always_comb begin
    is_padd = (op == AU_OP_PADD);
    b_eff   = (op == AU_OP_SUB) ? ~b : b;
    v_hi    = (~a[15] & ~b_eff[15] & sum[15]) | (a[15] & b_eff[15] & ~sum[15]);
    v_lo    = is_padd & ((~a[7] & ~b[7] & sum[7]) | (a[7] & b[7] & ~sum[7]));
    // True sign of the full word (ADD/SUB) or of the upper byte (PADD) is the same bit.
    neg     = sum[15] ^ v_hi;

    result = sum;
`ifdef AU_SATURATE_EN
    if (is_padd) begin
      if (v_hi) result[15:8] = neg ? 8'h80 : 8'h7F;
      if (v_lo) result[7:0]  = (sum[7] ^ v_lo) ? 8'h80 : 8'h7F;
    end else if (v_hi) begin
      result = neg ? 16'h8000 : 16'h7FFF;
    end
`endif

    flags         = '0;
    flags[FLAG_Z] = (result == 16'h0000);
    flags[FLAG_V] = v_hi | v_lo;
    flags[FLAG_N] = neg;
  end

endmodule

// File: rtl/au_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit AU between two requesters, with a
// single registered response stage. Saturation is selected by AU_SATURATE_EN (au_flag_sat).
module au_arbiter
  import au_pkg::*;
#(
  parameter int unsigned BURST_LEN = 1
) (
  input logic         clk,
  input logic         rst,
  au_arbiter_if.slave bus
);

  localparam logic [3:0] BurstMax = 4'(BURST_LEN - 1);

  logic        rsp_valid_q, rsp_id_q;
  logic [15:0] rsp_result_q;
  logic [2:0]  rsp_flags_q;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        started_q;

  logic        issue_ok, accept, winner;
  logic [1:0]  sel_op;
  logic [15:0] au_a, au_b, fin_result;
  logic [2:0]  fin_flags;

  always_comb begin
    issue_ok = ~rsp_valid_q | bus.rsp_ready;
    accept   = (bus.req0_valid | bus.req1_valid) & issue_ok & ~rst;

    if (bus.req0_valid && bus.req1_valid) begin
      // No burst exists before the first accept, so requester 0 takes the first grant.
      if (started_q && (burst_cnt_q < BurstMax)) winner = last_grant_q;
      else                                       winner = ~last_grant_q;
    end else begin
      winner = bus.req1_valid;
    end

    sel_op = winner ? bus.req1_op : bus.req0_op;
    au_a   = '0;
    au_b   = '0;
    if (accept) begin
      au_a = winner ? bus.req1_a : bus.req0_a;
      au_b = winner ? bus.req1_b : bus.req0_b;
    end

    last_grant_d = winner;
    burst_cnt_d  = '0;
    if (started_q && (winner == last_grant_q)) begin
      burst_cnt_d = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
    end
  end

  assign bus.req0_ready = accept & ~winner;
  assign bus.req1_ready = accept & winner;
  assign bus.au_cmd     = accept ? op_to_cmd(sel_op) : AU_CMD_ADD;
  assign bus.au_a       = au_a;
  assign bus.au_b       = au_b;

  au_flag_sat u_flag_sat (
    .op    (sel_op),
    .a     (au_a),
    .b     (au_b),
    .sum   (bus.au_sum),
    .result(fin_result),
    .flags (fin_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      last_grant_q <= 1'b1;
      burst_cnt_q  <= '0;
      started_q    <= 1'b0;
    end else if (accept) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= winner;
      rsp_result_q <= fin_result;
      rsp_flags_q  <= fin_flags;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      started_q    <= 1'b1;
    end else if (bus.rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_au_arbiter.sv
// Directed bench for au_arbiter: arithmetic/flags, round-robin and burst grants, response
// back-pressure and reset; one instance per BURST_LEN value (1 and 3).
module tb_au_arbiter;
  import au_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  au_arbiter_if bus1();
  au_arbiter_if bus3();

  au_arbiter #(.BURST_LEN(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  au_arbiter #(.BURST_LEN(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Behavioural shared adder: full 16-bit or two independent bytes, add or subtract.
  function automatic logic [15:0] au_model(input logic [3:0] cmd, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [7:0] hi, lo;
    if (cmd[3]) return cmd[1] ? a - b : a + b;
    hi = cmd[1] ? a[15:8] - b[15:8] : a[15:8] + b[15:8];
    lo = cmd[1] ? a[7:0] - b[7:0] : a[7:0] + b[7:0];
    return {hi, lo};
  endfunction

  assign bus1.au_sum = au_model(bus1.au_cmd, bus1.au_a, bus1.au_b);
  assign bus3.au_sum = au_model(bus3.au_cmd, bus3.au_a, bus3.au_b);

`ifdef AU_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus1.req0_valid = 0; bus1.req0_op = 0; bus1.req0_a = 0; bus1.req0_b = 0;
    bus1.req1_valid = 0; bus1.req1_op = 0; bus1.req1_a = 0; bus1.req1_b = 0;
    bus3.req0_valid = 0; bus3.req0_op = 0; bus3.req0_a = 0; bus3.req0_b = 0;
    bus3.req1_valid = 0; bus3.req1_op = 0; bus3.req1_a = 0; bus3.req1_b = 0;
    bus1.rsp_ready = 1; bus3.rsp_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // Both requesters of one bus: req0 ADD 0010+0001=0011, req1 SUB 0020-0001=001F.
  task automatic drive_both1();
    bus1.req0_valid = 1; bus1.req0_op = AU_OP_ADD; bus1.req0_a = 16'h0010; bus1.req0_b = 16'h0001;
    bus1.req1_valid = 1; bus1.req1_op = AU_OP_SUB; bus1.req1_a = 16'h0020; bus1.req1_b = 16'h0001;
  endtask

  task automatic issue0(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic rdy, output logic [3:0] cmd);
    bus1.req0_valid = 1; bus1.req0_op = op; bus1.req0_a = a; bus1.req0_b = b;
    #1;
    rdy = bus1.req0_ready;
    cmd = bus1.au_cmd;
    tick();
    bus1.req0_valid = 0;
  endtask

  task automatic test_reset();
    idle_all();
    drive_both1();
    rst = 1;
    #1;
    total++;
    if ({bus1.req0_ready, bus1.req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b want=00", {bus1.req0_ready, bus1.req1_ready});
    end
    tick();
    total++;
    if ({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_flags} !== 21'd0) begin
      bad++; $display("FAIL reset_rsp got v=%b id=%b r=%h f=%b want all zero",
                      bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_flags);
    end
    rst = 0;
    #1;
    total++;
    if ({bus1.req0_ready, bus1.req1_ready} !== 2'b10) begin
      bad++; $display("FAIL reset_first_grant got=%b want=10", {bus1.req0_ready, bus1.req1_ready});
    end
    idle_all();
    do_reset();
  endtask

  task automatic test_add();
    logic rdy;
    logic [3:0] cmd;
    issue0(AU_OP_ADD, 16'h0001, 16'h0002, rdy, cmd);
    total++;
    if (rdy !== 1'b1 || cmd !== 4'b1000) begin
      bad++; $display("FAIL add_issue got rdy=%b cmd=%b want rdy=1 cmd=1000", rdy, cmd);
    end
    total++;
    if ({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_flags} !== {2'b10, 16'h0003, 3'b000}) begin
      bad++; $display("FAIL add_rsp got v=%b id=%b r=%h f=%b want v=1 id=0 r=0003 f=000",
                      bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_flags);
    end
    tick();
    total++;
    if (bus1.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL add_drain got rsp_valid=%b want 0", bus1.rsp_valid);
    end
  endtask

  task automatic test_arith();
    logic [1:0]  ops  [6] = '{AU_OP_SUB, AU_OP_ADD, AU_OP_PADD, AU_OP_ADD, AU_OP_RSVD, AU_OP_PADD};
    logic [15:0] as   [6] = '{16'h0005, 16'h7FFF, 16'h7F01, 16'h8000, 16'h0003, 16'h80FF};
    logic [15:0] bs   [6] = '{16'h0005, 16'h0001, 16'h0101, 16'h8000, 16'h0004, 16'h80FF};
    logic [3:0]  cmds [6] = '{4'b1010, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    logic [15:0] res  [6];
    logic [2:0]  flg  [6];
    logic rdy;
    logic [3:0] cmd;
    res = '{16'h0000, Sat ? 16'h7FFF : 16'h8000, Sat ? 16'h7F02 : 16'h8002,
            Sat ? 16'h8000 : 16'h0000, 16'h0007, Sat ? 16'h80FE : 16'h00FE};
    flg = '{3'b100, 3'b010, 3'b010, Sat ? 3'b011 : 3'b111, 3'b000, 3'b011};
    for (int i = 0; i < 6; i++) begin
      issue0(ops[i], as[i], bs[i], rdy, cmd);
      total++;
      if (rdy !== 1'b1 || cmd !== cmds[i]) begin
        bad++; $display("FAIL arith_cmd[%0d] got rdy=%b cmd=%b want rdy=1 cmd=%b", i, rdy, cmd, cmds[i]);
      end
      total++;
      if (bus1.rsp_valid !== 1'b1 || bus1.rsp_result !== res[i] || bus1.rsp_flags !== flg[i]) begin
        bad++; $display("FAIL arith_rsp[%0d] got v=%b r=%h f=%b want v=1 r=%h f=%b", i,
                        bus1.rsp_valid, bus1.rsp_result, bus1.rsp_flags, res[i], flg[i]);
      end
    end
    tick();
  endtask

  task automatic test_alternate();
    logic e;
    idle_all();
    do_reset();
    drive_both1();
    for (int i = 0; i < 4; i++) begin
      e = 1'(i % 2);
      #1;
      total++;
      if ({bus1.req0_ready, bus1.req1_ready} !== {~e, e}) begin
        bad++; $display("FAIL alt_grant[%0d] got=%b want=%b", i,
                        {bus1.req0_ready, bus1.req1_ready}, {~e, e});
      end
      tick();
      total++;
      if (bus1.rsp_valid !== 1'b1 || bus1.rsp_id !== e ||
          bus1.rsp_result !== (e ? 16'h001F : 16'h0011)) begin
        bad++; $display("FAIL alt_rsp[%0d] got v=%b id=%b r=%h want v=1 id=%b r=%h", i,
                        bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, e, e ? 16'h001F : 16'h0011);
      end
    end
    idle_all();
  endtask

  task automatic test_burst();
    logic exp_g [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    idle_all();
    do_reset();
    bus3.req0_valid = 1; bus3.req0_op = AU_OP_ADD; bus3.req0_a = 16'h0100; bus3.req0_b = 16'h0001;
    bus3.req1_valid = 1; bus3.req1_op = AU_OP_ADD; bus3.req1_a = 16'h0200; bus3.req1_b = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if ({bus3.req0_ready, bus3.req1_ready} !== {~exp_g[i], exp_g[i]}) begin
        bad++; $display("FAIL burst_grant[%0d] got=%b want=%b", i,
                        {bus3.req0_ready, bus3.req1_ready}, {~exp_g[i], exp_g[i]});
      end
      tick();
      total++;
      if (bus3.rsp_valid !== 1'b1 || bus3.rsp_id !== exp_g[i]) begin
        bad++; $display("FAIL burst_rsp[%0d] got v=%b id=%b want v=1 id=%b", i,
                        bus3.rsp_valid, bus3.rsp_id, exp_g[i]);
      end
    end
    idle_all();
  endtask

  task automatic test_stall();
    idle_all();
    do_reset();
    drive_both1();
    bus1.rsp_ready = 0;
    #1;
    total++;
    if ({bus1.req0_ready, bus1.req1_ready} !== 2'b10) begin
      bad++; $display("FAIL stall_first got=%b want=10", {bus1.req0_ready, bus1.req1_ready});
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({bus1.req0_ready, bus1.req1_ready} !== 2'b00) begin
        bad++; $display("FAIL stall_ready[%0d] got=%b want=00", i, {bus1.req0_ready, bus1.req1_ready});
      end
      tick();
      total++;
      if (bus1.rsp_valid !== 1'b1 || bus1.rsp_id !== 1'b0 || bus1.rsp_result !== 16'h0011 ||
          bus1.rsp_flags !== 3'b000) begin
        bad++; $display("FAIL stall_hold[%0d] got v=%b id=%b r=%h f=%b want v=1 id=0 r=0011 f=000",
                        i, bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result, bus1.rsp_flags);
      end
    end
    bus1.rsp_ready = 1;
    #1;
    total++;
    if ({bus1.req0_ready, bus1.req1_ready} !== 2'b01) begin
      bad++; $display("FAIL stall_release got=%b want=01", {bus1.req0_ready, bus1.req1_ready});
    end
    tick();
    total++;
    if (bus1.rsp_valid !== 1'b1 || bus1.rsp_id !== 1'b1 || bus1.rsp_result !== 16'h001F) begin
      bad++; $display("FAIL stall_next got v=%b id=%b r=%h want v=1 id=1 r=001F",
                      bus1.rsp_valid, bus1.rsp_id, bus1.rsp_result);
    end
  endtask

  task automatic test_reset_mid();
    // Entered with a held response and both requesters still valid.
    bus1.rsp_ready = 1;
    rst = 1;
    #1;
    total++;
    if ({bus1.req0_ready, bus1.req1_ready} !== 2'b00) begin
      bad++; $display("FAIL rstmid_ready got=%b want=00", {bus1.req0_ready, bus1.req1_ready});
    end
    tick();
    total++;
    if (bus1.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_rsp got rsp_valid=%b want 0", bus1.rsp_valid);
    end
    rst = 0;
    #1;
    total++;
    if ({bus1.req0_ready, bus1.req1_ready} !== 2'b10) begin
      bad++; $display("FAIL rstmid_grant got=%b want=10", {bus1.req0_ready, bus1.req1_ready});
    end
    idle_all();
    tick();
  endtask

  initial begin
    rst = 1;
    idle_all();
    test_reset();
    test_add();
    test_arith();
    test_alternate();
    test_burst();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
